tx_frame_buffer: RTL and testbench

- Store-and-forward frame buffer directly downstream of flow_ctrl on the network TX path.
- Accepts the paced tx_*_net beat stream and holds each frame until its eof beat is written.
- Releases only complete frames to the MAC-side stream, so a stalled or truncated frame never reaches the wire.
- Frames that overflow the buffer, or are malformed, are discarded whole.

---
 rtl/tx_frame_buffer.sv | 180 ++++++++++++++++++
 tb/tb_tx_frame_buffer.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_frame_buffer.sv
// Store-and-forward TX frame buffer: only complete frames reach the MAC; overflowing or malformed frames are dropped whole.
// Define TX_FRAME_BUFFER_STATS_EN to build the frame_cnt/drop_cnt statistics counters (tied to 0 otherwise).
module tx_frame_buffer #(
    parameter int WIDTH     = 64,
    parameter int DEPTH     = 64,
    parameter int CNT_WIDTH = 32
) (
    input  logic                   clk_net,
    input  logic                   rst,
    input  logic [WIDTH-1:0]       in_data,
    input  logic [2:0]             in_len,
    input  logic                   in_sof,
    input  logic                   in_eof,
    input  logic                   in_vld,
    output logic                   in_ack,
    output logic [WIDTH-1:0]       out_data,
    output logic [2:0]             out_len,
    output logic                   out_sof,
    output logic                   out_eof,
    output logic                   out_vld,
    input  logic                   out_ack,
    output logic [$clog2(DEPTH):0] level,
    output logic [CNT_WIDTH-1:0]   frame_cnt,
    output logic [CNT_WIDTH-1:0]   drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int BW = WIDTH + 5;

    typedef enum logic [1:0] {W_IDLE, W_FRAME, W_DROP} wstate_t;

    logic [BW-1:0] mem [DEPTH];

    wstate_t       wst, wst_n;
    logic [AW-1:0] wptr, wptr_n, start_ptr, start_n, rptr, base;
    logic [LW-1:0] cur_len, cur_n, rew_len, commit_len, avail, frames_c;
    logic [AW-1:0] wr_addr;
    logic          acc, start_new, wr_en, commit;
    logic          fetch, rd_hs, eof_hs;

    assign acc    = in_vld & in_ack;
    assign rd_hs  = out_vld & out_ack;
    assign eof_hs = rd_hs & out_eof;
    assign fetch  = (!out_vld || out_ack) && (avail != '0) && (frames_c != '0);

    // A restarting sof rewinds to the frame start and is then handled like a fresh sof in the same cycle.
    always_comb begin
        start_new  = 1'b0;
        wr_en      = 1'b0;
        wr_addr    = wptr;
        commit     = 1'b0;
        commit_len = '0;
        rew_len    = '0;
        base       = wptr;
        wst_n      = wst;
        wptr_n     = wptr;
        start_n    = start_ptr;
        cur_n      = cur_len;
        if (acc) begin
            case (wst)
                W_IDLE: start_new = in_sof;
                W_FRAME: begin
                    if (in_sof) begin
                        rew_len   = cur_len;
                        base      = start_ptr;
                        start_new = 1'b1;
                    end else if (level == LW'(DEPTH)) begin
                        rew_len = cur_len;
                        wptr_n  = start_ptr;
                        cur_n   = '0;
                        wst_n   = in_eof ? W_IDLE : W_DROP;
                    end else begin
                        wr_en  = 1'b1;
                        wptr_n = wptr + AW'(1);
                        cur_n  = cur_len + LW'(1);
                        if (in_eof) begin
                            commit     = 1'b1;
                            commit_len = cur_len + LW'(1);
                            cur_n      = '0;
                            wst_n      = W_IDLE;
                        end
                    end
                end
                W_DROP: begin
                    if (in_eof) begin
                        wst_n     = W_IDLE;
                        start_new = in_sof;
                    end
                end
                default: wst_n = W_IDLE;
            endcase
            if (start_new) begin
                if (level - rew_len == LW'(DEPTH)) begin
                    wptr_n = base;
                    cur_n  = '0;
                    wst_n  = in_eof ? W_IDLE : W_DROP;
                end else begin
                    wr_en   = 1'b1;
                    wr_addr = base;
                    wptr_n  = base + AW'(1);
                    start_n = base;
                    if (in_eof) begin
                        commit     = 1'b1;
                        commit_len = LW'(1);
                        cur_n      = '0;
                        wst_n      = W_IDLE;
                    end else begin
                        cur_n = LW'(1);
                        wst_n = W_FRAME;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_net) begin
        if (wr_en) mem[wr_addr] <= {in_data, in_len, in_sof, in_eof};
    end

    always_ff @(posedge clk_net or posedge rst) begin
        if (rst) begin
            in_ack    <= 1'b0;
            wst       <= W_IDLE;
            wptr      <= '0;
            start_ptr <= '0;
            cur_len   <= '0;
            level     <= '0;
            avail     <= '0;
            frames_c  <= '0;
        end else begin
            in_ack    <= 1'b1;
            wst       <= wst_n;
            wptr      <= wptr_n;
            start_ptr <= start_n;
            cur_len   <= cur_n;
            level     <= level + LW'(wr_en) - LW'(rd_hs) - rew_len;
            avail     <= avail + commit_len - LW'(fetch);
            frames_c  <= frames_c + LW'(commit) - LW'(eof_hs);
        end
    end

    // Output register stage: refilled whenever empty or being consumed, so frames stream back-to-back.
    always_ff @(posedge clk_net or posedge rst) begin
        if (rst) begin
            out_vld  <= 1'b0;
            out_data <= '0;
            out_len  <= '0;
            out_sof  <= 1'b0;
            out_eof  <= 1'b0;
            rptr     <= '0;
        end else if (fetch) begin
            {out_data, out_len, out_sof, out_eof} <= mem[rptr];
            out_vld <= 1'b1;
            rptr    <= rptr + AW'(1);
        end else if (rd_hs) begin
            out_vld <= 1'b0;
        end
    end

`ifdef TX_FRAME_BUFFER_STATS_EN
    logic drop;
    assign drop = acc && (((wst == W_FRAME) && (in_sof || level == LW'(DEPTH)))
                  || (start_new && (level - rew_len == LW'(DEPTH))));

    always_ff @(posedge clk_net or posedge rst) begin
        if (rst) begin
            frame_cnt <= '0;
            drop_cnt  <= '0;
        end else begin
            if (eof_hs && frame_cnt != '1) frame_cnt <= frame_cnt + CNT_WIDTH'(1);
            if (drop && drop_cnt != '1)    drop_cnt  <= drop_cnt + CNT_WIDTH'(1);
        end
    end
`else
    assign frame_cnt = '0;
    assign drop_cnt  = '0;
`endif

endmodule

// File: tb/tb_tx_frame_buffer.sv
// Scoreboard bench for tx_frame_buffer: two instances (DEPTH 64 and 16) share one stimulus stream.
`timescale 1ns/1ps
module tb_tx_frame_buffer;

    localparam int W = 64;

    typedef struct packed {
        logic [W-1:0] data;
        logic [2:0]   len;
        logic         sof;
        logic         eof;
    } beat_t;

    logic         clk_net = 1'b0;
    logic         rst     = 1'b1;
    logic [W-1:0] in_data = '0;
    logic [2:0]   in_len  = '0;
    logic         in_sof  = 1'b0;
    logic         in_eof  = 1'b0;
    logic         in_vld  = 1'b0;
    logic         out_ack = 1'b0;

    logic         in_ack0, out_sof0, out_eof0, out_vld0;
    logic [W-1:0] out_data0;
    logic [2:0]   out_len0;
    logic [6:0]   level0;
    logic [31:0]  frame_cnt0, drop_cnt0;

    logic         in_ack1, out_sof1, out_eof1, out_vld1;
    logic [W-1:0] out_data1;
    logic [2:0]   out_len1;
    logic [4:0]   level1;
    logic [31:0]  frame_cnt1, drop_cnt1;

    tx_frame_buffer #(.WIDTH(64), .DEPTH(64), .CNT_WIDTH(32)) u_big (
        .clk_net(clk_net), .rst(rst),
        .in_data(in_data), .in_len(in_len), .in_sof(in_sof), .in_eof(in_eof),
        .in_vld(in_vld), .in_ack(in_ack0),
        .out_data(out_data0), .out_len(out_len0), .out_sof(out_sof0), .out_eof(out_eof0),
        .out_vld(out_vld0), .out_ack(out_ack),
        .level(level0), .frame_cnt(frame_cnt0), .drop_cnt(drop_cnt0)
    );

    tx_frame_buffer #(.WIDTH(64), .DEPTH(16), .CNT_WIDTH(32)) u_small (
        .clk_net(clk_net), .rst(rst),
        .in_data(in_data), .in_len(in_len), .in_sof(in_sof), .in_eof(in_eof),
        .in_vld(in_vld), .in_ack(in_ack1),
        .out_data(out_data1), .out_len(out_len1), .out_sof(out_sof1), .out_eof(out_eof1),
        .out_vld(out_vld1), .out_ack(out_ack),
        .level(level1), .frame_cnt(frame_cnt1), .drop_cnt(drop_cnt1)
    );

    always #5 clk_net = ~clk_net;

    int n_chk  = 0;
    int n_pass = 0;
    int ack_mode = 0;

    // Reference model: per instance, the in-progress frame and the queue of committed beats awaiting output.
    beat_t       exp_q [2][$];
    beat_t       cur_q [2][$];
    int          mode [2];       // 0 idle, 1 in frame, 2 discarding
    int unsigned exp_frames [2];
    int unsigned exp_drops [2];
    bit          hold_p [2];
    beat_t       hold_b [2];

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    endtask

    function automatic int dep(input int k);
        return (k == 0) ? 64 : 16;
    endfunction

    function automatic logic [31:0] stat(input int unsigned v);
`ifdef TX_FRAME_BUFFER_STATS_EN
        return v;
`else
        return (v == 32'hFFFF_FFFF) ? 32'd0 : 32'd0;
`endif
    endfunction

    task automatic commit(input int k);
        foreach (cur_q[k][i]) exp_q[k].push_back(cur_q[k][i]);
        cur_q[k].delete();
        exp_frames[k]++;
        mode[k] = 0;
    endtask

    task automatic new_frame(input int k, input beat_t b);
        int occ;
        occ = exp_q[k].size() + cur_q[k].size();
        if (occ == dep(k)) begin
            exp_drops[k]++;
            mode[k] = b.eof ? 0 : 2;
        end else begin
            cur_q[k].push_back(b);
            if (b.eof) commit(k);
            else mode[k] = 1;
        end
    endtask

    task automatic model_beat(input beat_t b);
        for (int k = 0; k < 2; k++) begin
            case (mode[k])
                0: if (b.sof) new_frame(k, b);
                1: begin
                    if (b.sof) begin
                        exp_drops[k]++;
                        cur_q[k].delete();
                        new_frame(k, b);
                    end else if (exp_q[k].size() + cur_q[k].size() == dep(k)) begin
                        exp_drops[k]++;
                        cur_q[k].delete();
                        mode[k] = b.eof ? 0 : 2;
                    end else begin
                        cur_q[k].push_back(b);
                        if (b.eof) commit(k);
                    end
                end
                default: begin
                    if (b.eof) begin
                        mode[k] = 0;
                        if (b.sof) new_frame(k, b);
                    end
                end
            endcase
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            exp_q[k].delete();
            cur_q[k].delete();
            mode[k] = 0;
            exp_frames[k] = 0;
            exp_drops[k] = 0;
        end
    endtask

    function automatic beat_t mk(input bit sof, input bit eof, input logic [2:0] len);
        beat_t b;
        b.data = {$urandom(), $urandom()};
        b.len  = len;
        b.sof  = sof;
        b.eof  = eof;
        return b;
    endfunction

    task automatic drive(input beat_t b);
        @(posedge clk_net); #1;
        in_data = b.data; in_len = b.len; in_sof = b.sof; in_eof = b.eof; in_vld = 1'b1;
        model_beat(b);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_net); #1;
            in_vld = 1'b0; in_sof = 1'b0; in_eof = 1'b0;
        end
    endtask

    task automatic send_frame(input int n, input logic [2:0] len, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) idle(1);
            drive(mk(i == 0, i == n - 1, (i == n - 1) ? len : 3'($urandom())));
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((exp_q[0].size() != 0 || exp_q[1].size() != 0) && t < 3000) begin
            @(posedge clk_net);
            t++;
        end
        if (t >= 3000) begin
            n_chk++;
            $display("FAIL drain_timeout: got %0d/%0d beats outstanding, expected 0", exp_q[0].size(), exp_q[1].size());
        end
        idle(3);
    endtask

    task automatic check_stats(input string tag);
        @(negedge clk_net);
        chk({tag, "_level0"}, level0, 0);
        chk({tag, "_level1"}, level1, 0);
        chk({tag, "_vld0"}, out_vld0, 0);
        chk({tag, "_vld1"}, out_vld1, 0);
        chk({tag, "_frames0"}, frame_cnt0, stat(exp_frames[0]));
        chk({tag, "_frames1"}, frame_cnt1, stat(exp_frames[1]));
        chk({tag, "_drops0"}, drop_cnt0, stat(exp_drops[0]));
        chk({tag, "_drops1"}, drop_cnt1, stat(exp_drops[1]));
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        in_vld = 1'b0; in_sof = 1'b0; in_eof = 1'b0;
        model_reset();
        repeat (2) @(negedge clk_net);
        chk("rst_ack", {in_ack0, in_ack1}, 0);
        chk("rst_out0", {out_vld0, out_sof0, out_eof0, out_len0, out_data0}, 0);
        chk("rst_out1", {out_vld1, out_sof1, out_eof1, out_len1, out_data1}, 0);
        chk("rst_level", {level0, level1}, 0);
        chk("rst_cnt", {frame_cnt0, drop_cnt0, frame_cnt1, drop_cnt1}, 0);
        rst = 1'b0;
        repeat (2) @(posedge clk_net);
        #1;
        chk("ack_after_rst", {in_ack0, in_ack1}, 2'b11);
    endtask

    task automatic mon(input int k, input logic vld, input beat_t o);
        beat_t e;
        if (hold_p[k]) chk($sformatf("hold_dut%0d", k), {vld, o}, {1'b1, hold_b[k]});
        hold_p[k] = vld && !out_ack;
        hold_b[k] = o;
        if (vld && out_ack) begin
            if (exp_q[k].size() == 0) begin
                n_chk++;
                $display("FAIL extra_beat_dut%0d: got data %0h, expected no beat", k, o.data);
            end else begin
                e = exp_q[k].pop_front();
                chk($sformatf("data_dut%0d", k), o.data, e.data);
                chk($sformatf("sofeof_dut%0d", k), {o.sof, o.eof}, {e.sof, e.eof});
                if (e.eof) chk($sformatf("len_dut%0d", k), o.len, e.len);
            end
        end
    endtask

    always @(negedge clk_net) begin
        if (rst) begin
            hold_p[0] = 1'b0;
            hold_p[1] = 1'b0;
        end else begin
            mon(0, out_vld0, {out_data0, out_len0, out_sof0, out_eof0});
            mon(1, out_vld1, {out_data1, out_len1, out_sof1, out_eof1});
        end
    end

    initial begin
        forever begin
            @(posedge clk_net); #1;
            case (ack_mode)
                0: out_ack = 1'b1;
                1: out_ack = ($urandom_range(0, 9) < 7);
                2: out_ack = ~out_ack;
                default: out_ack = 1'b0;
            endcase
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, p, l, need;
        hold_p[0] = 1'b0;
        hold_p[1] = 1'b0;
        reset_dut();

        // Two long frames: forwarded by the 64-deep instance, both overflow the 16-deep one.
        ack_mode = 0;
        send_frame(29, 3'd0, 1'b0);
        send_frame(21, 3'd3, 1'b0);
        idle(1);
        drain();
        check_stats("long");

        // 20-beat overflow then a 5-beat frame.
        send_frame(20, 3'd6, 1'b0);
        idle(1);
        @(negedge clk_net);
        chk("level_after_drop", level1, 0);
        send_frame(5, 3'd2, 1'b0);
        idle(1);
        drain();
        check_stats("ovf");

        // Abandoned 4-beat frame, restarted by a new sof.
        for (int i = 0; i < 4; i++) drive(mk(i == 0, 1'b0, 3'd1));
        send_frame(3, 3'd7, 1'b0);
        idle(1);
        drain();
        check_stats("restart");

        // Output stalls with out_ack alternating.
        ack_mode = 2;
        send_frame(8, 3'd4, 1'b0);
        idle(1);
        drain();
        ack_mode = 0;
        check_stats("toggle");

        // Single sof+eof beat: out_vld must be up within two edges of acceptance.
        ack_mode = 3;
        repeat (2) @(posedge clk_net);
        drive(mk(1'b1, 1'b1, 3'd5));
        idle(1);
        repeat (2) @(posedge clk_net);
        @(negedge clk_net);
        chk("single_out0", {out_vld0, out_sof0, out_eof0, out_len0}, {3'b111, 3'd5});
        chk("single_out1", {out_vld1, out_sof1, out_eof1, out_len1}, {3'b111, 3'd5});
        ack_mode = 0;
        drain();
        check_stats("single");

        // Reset in the middle of a frame.
        for (int i = 0; i < 3; i++) drive(mk(i == 0, 1'b0, 3'd0));
        #2;
        reset_dut();
        send_frame(2, 3'd1, 1'b0);
        idle(1);
        drain();
        check_stats("midrst");

        // Randomised traffic with stray beats, abandoned frames and random back-pressure.
        ack_mode = 1;
        for (int f = 0; f < 40; f++) begin
            l = $urandom_range(1, 12);
            p = ($urandom_range(0, 6) == 0) ? $urandom_range(1, 5) : 0;
            need = (p > l) ? p : l;
            t = 0;
            while (exp_q[1].size() + need > 14 && t < 2000) begin
                @(posedge clk_net);
                t++;
            end
            if (t >= 2000) begin
                n_chk++;
                $display("FAIL pace_timeout: got %0d beats queued, expected at most %0d", exp_q[1].size(), 14 - need);
            end
            if ($urandom_range(0, 9) == 0) drive(mk(1'b0, $urandom_range(0, 1) == 1, 3'($urandom())));
            for (int i = 0; i < p; i++) drive(mk(i == 0, 1'b0, 3'($urandom())));
            send_frame(l, 3'($urandom()), 1'b1);
            idle($urandom_range(1, 3));
        end
        ack_mode = 0;
        drain();
        check_stats("random");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
